// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction memory.
//   state_e          : load controller states (IDLE, LOAD)
//   NOP_CODE_DEFAULT : word presented on machineCode when no valid fetch is held
//   calc_pw()        : width of the bank-select field, never less than one bit
package instr_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_e;

  localparam logic [8:0] NOP_CODE_DEFAULT = 9'b0;

  function automatic int calc_pw(input int num_progs);
    return (num_progs <= 1) ? 1 : $clog2(num_progs);
  endfunction

endpackage

// File: rtl/instruction_memory_if.sv
// Load and fetch bus of the instruction memory.
//   master : the side that streams programs in and issues fetches
//   slave  : the instruction memory itself
// Signals:
//   prog_sel       bank for fetch, also the load target captured on load_start
//   load_start     one-cycle pulse opening a load into bank prog_sel
//   load_valid     load beat valid
//   load_data      load beat payload
//   load_last      final beat of a load
//   load_ready     memory is accepting beats
//   fetch_en       fetch request, low stalls the output
//   programCounter fetch address
//   machineCode    instruction word, one cycle after the fetch
//   code_valid     machineCode holds a real fetched word
//   loaded         per-bank program-present flags
//   load_count     words accepted in the current or most recent load
//   load_error     the last load ran past the end of its bank
interface instruction_memory_if
  import instr_mem_pkg::*;
#(
  parameter int W         = 9,
  parameter int D         = 12,
  parameter int NUM_PROGS = 4,
  parameter int PW        = calc_pw(NUM_PROGS)
) ();

  logic [PW-1:0]        prog_sel;
  logic                 load_start;
  logic                 load_valid;
  logic [W-1:0]         load_data;
  logic                 load_last;
  logic                 load_ready;
  logic                 fetch_en;
  logic [D-1:0]         programCounter;
  logic [W-1:0]         machineCode;
  logic                 code_valid;
  logic [NUM_PROGS-1:0] loaded;
  logic [D:0]           load_count;
  logic                 load_error;

  modport master (
    output prog_sel, load_start, load_valid, load_data, load_last,
           fetch_en, programCounter,
    input  load_ready, machineCode, code_valid, loaded, load_count, load_error
  );

  modport slave (
    input  prog_sel, load_start, load_valid, load_data, load_last,
           fetch_en, programCounter,
    output load_ready, machineCode, code_valid, loaded, load_count, load_error
  );

endinterface

// File: rtl/instr_mem_bank.sv
// One program bank: 2**D words of W bits.
//   clk           : rising-edge clock
//   we/waddr/wdata: synchronous write port
//   re/raddr/rdata: registered read port, rdata holds while re is low
module instr_mem_bank #(
  parameter int W = 9,
  parameter int D = 12
) (
  input  logic         clk,
  input  logic         we,
  input  logic [D-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic         re,
  input  logic [D-1:0] raddr,
  output logic [W-1:0] rdata
);

  logic [W-1:0] mem [2**D];

  // NOTE: the array and its read register have no reset; a reset port would
  // stop the array mapping onto block RAM, and the loaded flags already keep
  // stale contents from being served.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instruction_memory.sv
// Multi-bank instruction memory for the fetch stage.
//   clk     : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : load/fetch bus (slave side), see instruction_memory_if
// Banks are filled through the streaming load port and served with one cycle
// of registered latency. A bank reads as NOP until a load into it completes
// with load_last; a load that runs off the end of the bank sets load_error.
module instruction_memory
  import instr_mem_pkg::*;
#(
  parameter int           W         = 9,
  parameter int           D         = 12,
  parameter int           NUM_PROGS = 4,
  parameter logic [W-1:0] NOP_CODE  = W'(NOP_CODE_DEFAULT)
) (
  input logic                  clk,
  input logic                  reset_n,
  instruction_memory_if.slave  bus
);

  localparam int           PW      = calc_pw(NUM_PROGS);
  localparam logic [D-1:0] PTR_MAX = '1;
  localparam logic [D-1:0] PTR_ONE = D'(1);
  localparam logic [D:0]   CNT_ONE = (D+1)'(1);

  state_e               state_q, state_d;
  logic [PW-1:0]        tgt_q;
  logic [D-1:0]         ptr_q;
  logic [D:0]           count_q;
  logic                 err_q;
  logic [NUM_PROGS-1:0] loaded_q;
  logic                 valid_q;
  logic [PW-1:0]        src_q;

  logic [NUM_PROGS-1:0] sel_hit;
  logic [NUM_PROGS-1:0] tgt_hit;
  logic                 start_ok;
  logic                 fetch_hit;
  logic                 beat;
  logic                 beat_end;
  logic [NUM_PROGS-1:0] bank_we;
  logic [NUM_PROGS-1:0] bank_re;
  logic [W-1:0]         rdata [NUM_PROGS];
  logic [W-1:0]         code_mux;

  // Decode prog_sel and the captured target. Out-of-range selects match no
  // bank, so they neither start a load nor hit on fetch.
  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, so no path leaves it unassigned and infers a latch.
  always_comb begin
    sel_hit = '0;
    tgt_hit = '0;
    for (int i = 0; i < NUM_PROGS; i++) begin
      sel_hit[i] = (bus.prog_sel == PW'(i));
      tgt_hit[i] = (tgt_q == PW'(i));
    end
    start_ok  = |sel_hit;
    fetch_hit = bus.fetch_en && |(sel_hit & loaded_q);
    beat      = (state_q == LOAD) && bus.load_valid;
    // The beat at the final address ends the load whether or not it is last.
    beat_end  = beat && (bus.load_last || (ptr_q == PTR_MAX));
  end

  // FSM state register.
  // NOTE: clocked blocks use non-blocking assignments so every register samples
  // values from before the edge; blocking assignments would make the result
  // depend on process evaluation order.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state. load_start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.load_start && start_ok) state_d = LOAD;
      LOAD: if (beat_end)                   state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.load_ready = (state_q == LOAD);
  end

  // Load datapath: target, write pointer, beat counter, flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tgt_q    <= '0;
      ptr_q    <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      loaded_q <= '0;
    end else if ((state_q == IDLE) && bus.load_start && start_ok) begin
      tgt_q    <= bus.prog_sel;
      ptr_q    <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      // Dropping the flag now keeps a half-written bank from ever being served.
      loaded_q <= loaded_q & ~sel_hit;
    end else if (beat) begin
      ptr_q   <= ptr_q + PTR_ONE;
      count_q <= count_q + CNT_ONE;
      if (bus.load_last)          loaded_q <= loaded_q | tgt_hit;
      else if (ptr_q == PTR_MAX)  err_q    <= 1'b1;
    end
  end

  // Bank ports. Only a loaded bank is ever read and only an unloaded bank is
  // ever written, so a bank never sees a read and a write in the same cycle.
  always_comb begin
    bank_we = '0;
    bank_re = '0;
    for (int i = 0; i < NUM_PROGS; i++) begin
      bank_we[i] = beat && tgt_hit[i];
      bank_re[i] = bus.fetch_en && sel_hit[i] && loaded_q[i];
    end
  end

  for (genvar g = 0; g < NUM_PROGS; g++) begin : g_bank
    instr_mem_bank #(
      .W (W),
      .D (D)
    ) u_bank (
      .clk   (clk),
      .we    (bank_we[g]),
      .waddr (ptr_q),
      .wdata (bus.load_data),
      .re    (bank_re[g]),
      .raddr (bus.programCounter),
      .rdata (rdata[g])
    );
  end

  // Fetch tracking: which bank's read register holds the word, and whether it
  // is real. Both hold on a stall, as do the bank read registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      src_q   <= '0;
    end else if (bus.fetch_en) begin
      valid_q <= fetch_hit;
      src_q   <= bus.prog_sel;
    end
  end

  always_comb begin
    code_mux = NOP_CODE;
    for (int i = 0; i < NUM_PROGS; i++) begin
      if (src_q == PW'(i)) code_mux = rdata[i];
    end
    bus.machineCode = valid_q ? code_mux : NOP_CODE;
  end

  assign bus.code_valid = valid_q;
  assign bus.loaded     = loaded_q;
  assign bus.load_count = count_q;
  assign bus.load_error = err_q;

endmodule

// File: tb/tb_instruction_memory.sv
// Scoreboard bench for instruction_memory. The driver pushes the expected value
// of each observed signal tagged with the cycle it must appear in; a monitor on
// the falling edge pops and compares. Two instances: the default geometry
// (D=12) and a small one (D=3) for overflow and end-of-bank loads.
module tb_instruction_memory;

  typedef enum {
    K_CODE, K_VALID, K_LOADED, K_COUNT, K_ERR, K_READY,
    K_O_CODE, K_O_VALID, K_O_LOADED, K_O_COUNT, K_O_ERR, K_O_READY
  } kind_e;

  typedef struct {
    int          cyc;
    kind_e       kind;
    logic [31:0] val;
    string       nm;
  } item_t;

  logic  clk = 1'b0;
  logic  reset_n;
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  item_t sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instruction_memory_if #(.W(9), .D(12), .NUM_PROGS(4)) bus ();
  instruction_memory_if #(.W(9), .D(3),  .NUM_PROGS(4)) obus ();

  instruction_memory #(.W(9), .D(12), .NUM_PROGS(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  instruction_memory #(.W(9), .D(3), .NUM_PROGS(4)) dut_ovf (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (obus)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] actual(input kind_e k);
    case (k)
      K_CODE:     return 32'(bus.machineCode);
      K_VALID:    return 32'(bus.code_valid);
      K_LOADED:   return 32'(bus.loaded);
      K_COUNT:    return 32'(bus.load_count);
      K_ERR:      return 32'(bus.load_error);
      K_READY:    return 32'(bus.load_ready);
      K_O_CODE:   return 32'(obus.machineCode);
      K_O_VALID:  return 32'(obus.code_valid);
      K_O_LOADED: return 32'(obus.loaded);
      K_O_COUNT:  return 32'(obus.load_count);
      K_O_ERR:    return 32'(obus.load_error);
      default:    return 32'(obus.load_ready);
    endcase
  endfunction

  // Monitor: compare everything due at or before the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      item_t it;
      it = sb.pop_front();
      check(it.nm, actual(it.kind), it.val);
    end
  end

  // Expected value for the edge following the current drive.
  task automatic push(input kind_e k, input logic [31:0] v, input string nm);
    item_t it;
    it.cyc  = cyc + 1;
    it.kind = k;
    it.val  = v;
    it.nm   = nm;
    sb.push_back(it);
  endtask

  task automatic push_reset_state(input string tag);
    push(K_CODE,   32'h0, {tag, "_code"});
    push(K_VALID,  32'h0, {tag, "_valid"});
    push(K_LOADED, 32'h0, {tag, "_loaded"});
    push(K_COUNT,  32'h0, {tag, "_count"});
    push(K_ERR,    32'h0, {tag, "_err"});
    push(K_READY,  32'h0, {tag, "_ready"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bus.prog_sel = '0;  bus.load_start = 0;  bus.load_valid = 0;
    bus.load_data = '0; bus.load_last = 0;   bus.fetch_en = 0;
    bus.programCounter = '0;
    obus.prog_sel = '0;  obus.load_start = 0; obus.load_valid = 0;
    obus.load_data = '0; obus.load_last = 0;  obus.fetch_en = 0;
    obus.programCounter = '0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    push_reset_state("reset");
    push(K_O_READY, 32'h0, "reset_o_ready");
    push(K_O_ERR,   32'h0, "reset_o_err");

    // Fetch from an empty bank returns NOP.
    @(negedge clk);
    reset_n = 1'b1;
    bus.fetch_en = 1; bus.prog_sel = 2'd0; bus.programCounter = 12'd5;
    push(K_CODE,   32'h0, "empty_code");
    push(K_VALID,  32'h0, "empty_valid");
    push(K_LOADED, 32'h0, "empty_loaded");

    // Small instance: overflow, 9 beats into bank3 without load_last.
    @(negedge clk);
    bus.fetch_en = 0;
    obus.load_start = 1; obus.prog_sel = 2'd3;
    push(K_O_READY, 32'h1, "ovf_start_ready");
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      obus.load_start = 0; obus.load_valid = 1;
      obus.load_data = 9'(9'h010 + i); obus.load_last = 0;
      if (i == 7) begin
        push(K_O_COUNT,  32'd8, "ovf_count");
        push(K_O_ERR,    32'h1, "ovf_err");
        push(K_O_READY,  32'h0, "ovf_ready_low");
        push(K_O_LOADED, 32'h0, "ovf_loaded");
      end
      if (i == 8) begin
        push(K_O_COUNT, 32'd8, "ovf_extra_ignored");
        push(K_O_READY, 32'h0, "ovf_extra_ready");
      end
    end

    // Small instance: load_last on the final address is legal.
    @(negedge clk);
    obus.load_valid = 0; obus.load_start = 1; obus.prog_sel = 2'd0;
    push(K_O_ERR,   32'h0, "edge_err_cleared");
    push(K_O_COUNT, 32'h0, "edge_count_cleared");
    push(K_O_READY, 32'h1, "edge_ready");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      obus.load_start = 0; obus.load_valid = 1;
      obus.load_data = 9'(9'h020 + i); obus.load_last = (i == 7);
    end
    push(K_O_LOADED, 32'h1, "edge_loaded");
    push(K_O_ERR,    32'h0, "edge_err");
    push(K_O_COUNT,  32'd8, "edge_count");
    push(K_O_READY,  32'h0, "edge_ready_low");
    @(negedge clk);
    obus.load_valid = 0; obus.load_last = 0;
    obus.fetch_en = 1; obus.prog_sel = 2'd0; obus.programCounter = 3'd7;
    push(K_O_CODE,  32'h027, "edge_fetch_code");
    push(K_O_VALID, 32'h1,   "edge_fetch_valid");
    @(negedge clk);
    obus.fetch_en = 0;

    // Load bank1 with 1..8 and one bubble after the third beat.
    @(negedge clk);
    bus.load_start = 1; bus.prog_sel = 2'd1;
    push(K_READY, 32'h1, "ld1_ready");
    push(K_COUNT, 32'h0, "ld1_count0");
    begin
      int k;
      k = 1;
      for (int s = 0; s < 9; s++) begin
        @(negedge clk);
        bus.load_start = 0;
        if (s == 3) begin
          bus.load_valid = 0;
          push(K_COUNT, 32'd3, "ld1_bubble_count");
        end else begin
          bus.load_valid = 1; bus.load_data = 9'(k); bus.load_last = (k == 8);
          k++;
        end
      end
    end
    push(K_LOADED, 32'h2, "ld1_loaded");
    push(K_COUNT,  32'd8, "ld1_count");
    push(K_READY,  32'h0, "ld1_ready_low");

    // Fetch bank1 pc=3.
    @(negedge clk);
    bus.load_valid = 0; bus.load_last = 0;
    bus.fetch_en = 1; bus.prog_sel = 2'd1; bus.programCounter = 12'd3;
    push(K_CODE,  32'h004, "fetch1_code");
    push(K_VALID, 32'h1,   "fetch1_valid");

    // Stall for three cycles while pc and prog_sel wander.
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      bus.fetch_en = 0; bus.prog_sel = 2'(s); bus.programCounter = 12'(s * 37 + 1);
      push(K_CODE,  32'h004, "stall_code");
      push(K_VALID, 32'h1,   "stall_valid");
    end

    // Load bank2 while fetching bank1 every cycle.
    @(negedge clk);
    bus.load_start = 1; bus.prog_sel = 2'd2;
    push(K_CODE,   32'h004, "conc_start_code");
    push(K_VALID,  32'h1,   "conc_start_valid");
    push(K_READY,  32'h1,   "conc_ready");
    push(K_LOADED, 32'h2,   "conc_loaded_during");
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      bus.load_start = 0; bus.load_valid = 1;
      bus.load_data = 9'(9'h1A0 + b); bus.load_last = (b == 3);
      bus.fetch_en = 1; bus.prog_sel = 2'd1; bus.programCounter = 12'(b + 4);
      push(K_CODE,  32'(b + 5), "conc_code");
      push(K_VALID, 32'h1,      "conc_valid");
    end
    @(negedge clk);
    bus.load_valid = 0; bus.load_last = 0; bus.programCounter = 12'd7;
    push(K_CODE,   32'h008, "conc_tail_code");
    push(K_LOADED, 32'h6,   "conc_loaded");
    push(K_COUNT,  32'd4,   "conc_count");
    @(negedge clk);
    bus.prog_sel = 2'd2; bus.programCounter = 12'd2;
    push(K_CODE,  32'h1A2, "bank2_code");
    push(K_VALID, 32'h1,   "bank2_valid");

    // Reload bank1: the same-cycle fetch still returns old data.
    @(negedge clk);
    bus.load_start = 1; bus.prog_sel = 2'd1; bus.programCounter = 12'd5;
    push(K_CODE,   32'h006, "reload_code");
    push(K_VALID,  32'h1,   "reload_valid");
    push(K_LOADED, 32'h4,   "reload_loaded");
    @(negedge clk);
    bus.load_start = 0; bus.fetch_en = 0;
    bus.load_valid = 1; bus.load_data = 9'h055;
    push(K_COUNT, 32'd1, "reload_count1");
    @(negedge clk);
    bus.load_data = 9'h066;
    push(K_COUNT, 32'd2, "reload_count2");

    // Reset in the middle of the load.
    @(negedge clk);
    bus.load_valid = 0; reset_n = 1'b0;
    push_reset_state("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    bus.fetch_en = 1; bus.prog_sel = 2'd1; bus.programCounter = 12'd0;
    push(K_CODE,  32'h0, "post_reset_code");
    push(K_VALID, 32'h0, "post_reset_valid");
    @(negedge clk);
    bus.fetch_en = 0;

    // Drain the scoreboard with a bounded wait.
    for (int t = 0; t < 20 && sb.size() > 0; t++) @(negedge clk);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expected items never compared, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
